// File: rtl/conv_punct_enc.sv
// ---------------------------------------------------------------------------
// conv_punct_enc
// Parametrised rate-1/2 mother convolutional encoder with run-time selectable
// puncturing (1/2, 2/3, 3/4, 5/6). Frames are delimited by i_last and use
// valid/ready handshakes on input and output.
//
// Optional build feature: define CONV_PUNCT_TAIL_EN to add zero-tail
// termination (K-1 zero bits injected after the last info bit, o_last on the
// last tail beat). Without it the beat of the i_last bit carries o_last and
// the encoder reinitialises immediately for the next frame.
//
// Ports:
//   clock, reset    clock; asynchronous active-high reset
//   i_data/i_valid  information bit and its valid
//   i_last          last information bit of a frame
//   i_ready         encoder accepts i_data this cycle
//   i_rate          0=1/2 1=2/3 2=3/4 3=5/6, sampled on the first bit of a frame
//   o_data          coded bits, o_data[0] filled first
//   o_valid         00 none, 01 o_data[0] only, 11 both
//   o_last          last beat of the frame
//   o_ready         downstream accepts the output beat
// ---------------------------------------------------------------------------
module conv_punct_enc #(
  parameter int                    POLY_DEPTH    = 7,
  parameter logic [POLY_DEPTH-1:0] POLY_A        = 7'b1001111,
  parameter logic [POLY_DEPTH-1:0] POLY_B        = 7'b1101101,
  parameter logic [POLY_DEPTH-1:0] DEFAULT_STATE = 7'b0000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       i_ready,
  input  logic [1:0] i_rate,
  output logic [1:0] o_data,
  output logic [1:0] o_valid,
  output logic       o_last,
  input  logic       o_ready
);

  localparam int K = POLY_DEPTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
`ifdef CONV_PUNCT_TAIL_EN
  localparam logic [1:0] S_TAIL = 2'd2;
  // Tail counter value of the last of the K-1 tail bits.
  localparam logic [3:0] TAIL_LAST = 4'(K - 2);
`endif

  // The top bit of DEFAULT_STATE has no storage behind it.
  localparam logic [K-2:0] INIT_STATE = DEFAULT_STATE[K-2:0];

  // XOR-reduce of a tapped encoder vector (one generator output bit).
  function automatic logic parity(input logic [K-1:0] x);
    parity = ^x;
  endfunction

  // Puncturing period for a rate code.
  function automatic logic [2:0] period_of(input logic [1:0] rate);
    case (rate)
      2'd0:    period_of = 3'd1;
      2'd1:    period_of = 3'd2;
      2'd2:    period_of = 3'd3;
      2'd3:    period_of = 3'd5;
      default: period_of = 3'd1;
    endcase
  endfunction

  logic [1:0]   r_fsm;
  logic [K-2:0] r_state;
  logic [2:0]   r_phase;
  logic [1:0]   r_rate;
  logic [1:0]   r_o_data;
  logic [1:0]   r_o_valid;
  logic         r_o_last;
`ifdef CONV_PUNCT_TAIL_EN
  logic [3:0]   r_tail_cnt;
  logic [3:0]   w_tail_nxt;
  logic         w_in_tail;
`endif

  logic         w_load;
  logic         w_i_ready;
  logic         w_accept;
  logic         w_enc;
  logic         w_bit;
  logic [1:0]   w_rate;
  logic [2:0]   w_period;
  logic [K-1:0] w_vec;
  logic         w_a;
  logic         w_b;
  logic [2:0]   w_phase_adv;
  logic [1:0]   w_beat_data;
  logic [1:0]   w_beat_valid;
  logic         w_beat_last;
  logic [1:0]   w_fsm_nxt;
  logic [K-2:0] w_state_nxt;
  logic [2:0]   w_phase_nxt;
  logic [1:0]   w_rate_nxt;

  // Output register may take a new beat when it is empty or being drained.
  assign w_load    = (r_o_valid == 2'b00) || o_ready;
  assign w_i_ready = !reset && ((r_fsm == S_IDLE) || (r_fsm == S_DATA)) && w_load;
  assign w_accept  = i_valid && w_i_ready;

`ifdef CONV_PUNCT_TAIL_EN
  assign w_in_tail = (r_fsm == S_TAIL);
  // Tail bits are injected only in cycles where the output register loads.
  assign w_enc     = w_accept || (w_in_tail && w_load);
  assign w_bit     = w_in_tail ? 1'b0 : i_data;
`else
  assign w_enc     = w_accept;
  assign w_bit     = i_data;
`endif

  // The first bit of a frame is encoded in IDLE with the rate on the port.
  assign w_rate      = (r_fsm == S_IDLE) ? i_rate : r_rate;
  assign w_period    = period_of(w_rate);
  assign w_vec       = {w_bit, r_state};
  assign w_a         = parity(w_vec & POLY_A);
  assign w_b         = parity(w_vec & POLY_B);
  assign w_phase_adv = (r_phase >= (w_period - 3'd1)) ? 3'd0 : (r_phase + 3'd1);

  // Puncture map: phase 0 keeps A and B, odd phases keep A, even phases keep B.
  always_comb begin
    w_beat_data  = 2'b00;
    w_beat_valid = 2'b00;
    if (r_phase == 3'd0) begin
      w_beat_data  = {w_b, w_a};
      w_beat_valid = 2'b11;
    end else if (r_phase[0]) begin
      w_beat_data  = {1'b0, w_a};
      w_beat_valid = 2'b01;
    end else begin
      w_beat_data  = {1'b0, w_b};
      w_beat_valid = 2'b01;
    end
  end

`ifdef CONV_PUNCT_TAIL_EN
  assign w_beat_last = w_in_tail && (r_tail_cnt == TAIL_LAST);
`else
  assign w_beat_last = w_accept && i_last;
`endif

  // Next-state logic for the frame FSM, encoder shift register, phase and rate.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_rate_nxt  = r_rate;
`ifdef CONV_PUNCT_TAIL_EN
    w_tail_nxt  = r_tail_cnt;
`endif
    case (r_fsm)
      S_IDLE, S_DATA: begin
        if (w_accept) begin
          if (r_fsm == S_IDLE) begin
            w_rate_nxt = i_rate;
          end else begin
            w_rate_nxt = r_rate;
          end
          w_state_nxt = w_vec[K-1:1];
          w_phase_nxt = w_phase_adv;
          if (i_last) begin
`ifdef CONV_PUNCT_TAIL_EN
            w_fsm_nxt  = S_TAIL;
            w_tail_nxt = 4'd0;
`else
            // No tail: reinitialise straight away for the next frame.
            w_fsm_nxt   = S_IDLE;
            w_state_nxt = INIT_STATE;
            w_phase_nxt = 3'd0;
`endif
          end else begin
            w_fsm_nxt = S_DATA;
          end
        end else begin
          w_fsm_nxt = r_fsm;
        end
      end
`ifdef CONV_PUNCT_TAIL_EN
      S_TAIL: begin
        if (w_load) begin
          w_state_nxt = w_vec[K-1:1];
          w_phase_nxt = w_phase_adv;
          if (r_tail_cnt == TAIL_LAST) begin
            w_fsm_nxt   = S_IDLE;
            w_state_nxt = INIT_STATE;
            w_phase_nxt = 3'd0;
          end else begin
            w_tail_nxt = r_tail_cnt + 4'd1;
          end
        end else begin
          w_fsm_nxt = S_TAIL;
        end
      end
`endif
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_state_nxt = INIT_STATE;
        w_phase_nxt = 3'd0;
      end
    endcase
  end

  // Frame FSM and encoder state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm   <= S_IDLE;
      r_state <= INIT_STATE;
      r_phase <= 3'd0;
      r_rate  <= 2'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_rate  <= w_rate_nxt;
    end
  end

`ifdef CONV_PUNCT_TAIL_EN
  // Tail bit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tail_cnt <= 4'd0;
    end else begin
      r_tail_cnt <= w_tail_nxt;
    end
  end
`endif

  // Output beat register; holds while a beat is stalled by o_ready=0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_o_data  <= 2'b00;
      r_o_valid <= 2'b00;
      r_o_last  <= 1'b0;
    end else if (w_load) begin
      if (w_enc) begin
        r_o_data  <= w_beat_data;
        r_o_valid <= w_beat_valid;
        r_o_last  <= w_beat_last;
      end else begin
        r_o_data  <= 2'b00;
        r_o_valid <= 2'b00;
        r_o_last  <= 1'b0;
      end
    end else begin
      r_o_data  <= r_o_data;
      r_o_valid <= r_o_valid;
      r_o_last  <= r_o_last;
    end
  end

  assign i_ready = w_i_ready;
  assign o_data  = r_o_data;
  assign o_valid = r_o_valid;
  assign o_last  = r_o_last;

endmodule
